// File: rtl/byte_block_loader_pkg.sv
// Shared constants, state encoding and block-size helper for the byte block loader.
package byte_block_loader_pkg;

    localparam int KMAX        = 6144;
    localparam int KSMALL      = 1056;
    localparam int DW          = 8;
    localparam int CW          = 10;
    localparam int BYTES_LARGE = KMAX / DW;
    localparam int BYTES_SMALL = KSMALL / DW;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        FULL = 2'd2
    } state_t;

    // Number of bytes that complete a block of the given K.
    function automatic logic [CW-1:0] block_bytes(input logic k6144);
        return k6144 ? CW'(BYTES_LARGE) : CW'(BYTES_SMALL);
    endfunction

endpackage

// File: rtl/byte_block_loader_ctrl.sv
// Loader control: block FSM, byte counter, K latch and valid/ready handshake.
module byte_block_loader_ctrl
    import byte_block_loader_pkg::*;
(
    input  logic          clk,
    input  logic          aclr_n,
    input  logic          k_size_6144,
    input  logic          in_valid,
    input  logic          in_sof,
    input  logic          blk_ack,
    output logic          in_ready,
    output logic          blk_valid,
    output logic          blk_k6144,
    output logic [CW-1:0] byte_cnt,
    output logic          restart_err,
    output logic          buf_load,
    output logic          buf_clear
);

    state_t state;
    logic   accept;

    assign accept    = in_valid && in_ready;
    assign buf_load  = accept;
    assign buf_clear = accept && ((state == IDLE) || in_sof);

    // in_ready is a register so in_valid never reaches it combinationally.
    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            state       <= IDLE;
            in_ready    <= 1'b1;
            blk_valid   <= 1'b0;
            blk_k6144   <= 1'b0;
            byte_cnt    <= '0;
            restart_err <= 1'b0;
        end else begin
            restart_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        blk_k6144 <= k_size_6144;
                        byte_cnt  <= CW'(1);
                        state     <= LOAD;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        if (in_sof) begin
                            restart_err <= (byte_cnt != '0);
                            blk_k6144   <= k_size_6144;
                            byte_cnt    <= CW'(1);
                        end else begin
                            byte_cnt <= byte_cnt + CW'(1);
                            if (byte_cnt + CW'(1) == block_bytes(blk_k6144)) begin
                                state     <= FULL;
                                in_ready  <= 1'b0;
                                blk_valid <= 1'b1;
                            end
                        end
                    end
                end
                FULL: begin
                    if (blk_ack) begin
                        state     <= IDLE;
                        in_ready  <= 1'b1;
                        blk_valid <= 1'b0;
                        byte_cnt  <= '0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    blk_valid <= 1'b0;
                    byte_cnt  <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/byte_block_loader.sv
// Byte-wise stream to KMAX-bit code block assembler feeding the coder interleaver.
module byte_block_loader
    import byte_block_loader_pkg::*;
(
    input  logic            clk,
    input  logic            aclr_n,
    input  logic            k_size_6144,
    input  logic [DW-1:0]   in_data,
    input  logic            in_valid,
    input  logic            in_sof,
    output logic            in_ready,
    output logic [KMAX-1:0] blk_data,
    output logic            blk_k6144,
    output logic            blk_valid,
    input  logic            blk_ack,
    output logic [CW-1:0]   byte_cnt,
    output logic            restart_err
);

    logic buf_load;
    logic buf_clear;

    byte_block_loader_ctrl u_ctrl (
        .clk         (clk),
        .aclr_n      (aclr_n),
        .k_size_6144 (k_size_6144),
        .in_valid    (in_valid),
        .in_sof      (in_sof),
        .blk_ack     (blk_ack),
        .in_ready    (in_ready),
        .blk_valid   (blk_valid),
        .blk_k6144   (blk_k6144),
        .byte_cnt    (byte_cnt),
        .restart_err (restart_err),
        .buf_load    (buf_load),
        .buf_clear   (buf_clear)
    );

    // Clearing on the first byte leaves the unused upper bits zero for short blocks.
    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            blk_data <= '0;
        end else if (buf_clear) begin
            blk_data <= {{(KMAX-DW){1'b0}}, in_data};
        end else if (buf_load) begin
            blk_data <= {blk_data[KMAX-DW-1:0], in_data};
        end
    end

endmodule

// File: tb/tb_byte_block_loader.sv
// Directed and randomized bench for byte_block_loader against a queue-based block model.
module tb_byte_block_loader;
    import byte_block_loader_pkg::*;

    logic            clk;
    logic            aclr_n;
    logic            k_size_6144;
    logic [DW-1:0]   in_data;
    logic            in_valid;
    logic            in_sof;
    logic            in_ready;
    logic [KMAX-1:0] blk_data;
    logic            blk_k6144;
    logic            blk_valid;
    logic            blk_ack;
    logic [CW-1:0]   byte_cnt;
    logic            restart_err;

    int errors = 0;
    int checks = 0;

    logic [7:0] m_q[$];
    bit         m_full;
    int         m_cnt;
    bit         m_k;
    bit         m_restart;

    byte_block_loader dut (
        .clk         (clk),
        .aclr_n      (aclr_n),
        .k_size_6144 (k_size_6144),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_sof      (in_sof),
        .in_ready    (in_ready),
        .blk_data    (blk_data),
        .blk_k6144   (blk_k6144),
        .blk_valid   (blk_valid),
        .blk_ack     (blk_ack),
        .byte_cnt    (byte_cnt),
        .restart_err (restart_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Most recently accepted byte sits in the lowest lane, earlier ones above it.
    function automatic logic [KMAX-1:0] model_data();
        logic [KMAX-1:0] r;
        int n;
        r = '0;
        n = m_q.size();
        for (int i = 0; i < n; i++) r[8*(n-1-i) +: 8] = m_q[i];
        return r;
    endfunction

    task automatic chk_data(input string tag);
        logic [KMAX-1:0] e;
        int idx;
        e = model_data();
        idx = 0;
        checks++;
        assert (blk_data === e) else begin
            errors++;
            for (int i = KMAX/DW-1; i >= 0; i--)
                if (blk_data[8*i +: 8] !== e[8*i +: 8]) idx = i;
            $error("FAIL %s lane=%0d observed=%h expected=%h", tag, idx, blk_data[8*idx +: 8], e[8*idx +: 8]);
        end
    endtask

    task automatic check_state();
        chk("in_ready",    32'(in_ready),    32'(!m_full));
        chk("blk_valid",   32'(blk_valid),   32'(m_full));
        chk("byte_cnt",    32'(byte_cnt),    32'(m_cnt));
        chk("blk_k6144",   32'(blk_k6144),   32'(m_k));
        chk("restart_err", 32'(restart_err), 32'(m_restart));
        chk_data("blk_data");
    endtask

    function automatic void model_reset();
        m_q.delete();
        m_full    = 1'b0;
        m_cnt     = 0;
        m_k       = 1'b0;
        m_restart = 1'b0;
    endfunction

    // One clock cycle: drive at the falling edge, check the pre-edge outputs, advance the model.
    task automatic apply_stimulus(input logic v, input logic [7:0] d, input logic sof,
                                  input logic k, input logic ack);
        in_valid    = v;
        in_data     = d;
        in_sof      = sof;
        k_size_6144 = k;
        blk_ack     = ack;
        check_state();
        m_restart = 1'b0;
        if (m_full) begin
            if (ack) begin
                m_full = 1'b0;
                m_cnt  = 0;
            end
        end else if (v) begin
            if (m_cnt == 0 || sof) begin
                m_restart = (m_cnt != 0);
                m_q.delete();
                m_q.push_back(d);
                m_k   = k;
                m_cnt = 1;
            end else begin
                m_q.push_back(d);
                m_cnt++;
            end
            if (m_cnt == (m_k ? KMAX/DW : KSMALL/DW)) m_full = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic sof, input logic k, input int max_gap);
        int gap;
        gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
        repeat (gap) apply_stimulus(1'b0, 8'($urandom), 1'b0, 1'($urandom), 1'b0);
        apply_stimulus(1'b1, d, sof, k, 1'b0);
    endtask

    // Asserts reset between clock edges so the outputs must clear without a clock.
    task automatic apply_reset();
        #2 aclr_n = 1'b0;
        in_valid = 1'b0;
        blk_ack  = 1'b0;
        in_sof   = 1'b0;
        #1;
        model_reset();
        chk("rst_blk_valid",   32'(blk_valid),   32'd0);
        chk("rst_byte_cnt",    32'(byte_cnt),    32'd0);
        chk("rst_restart_err", 32'(restart_err), 32'd0);
        chk("rst_blk_k6144",   32'(blk_k6144),   32'd0);
        chk_data("rst_blk_data");
        @(negedge clk);
        #2 aclr_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [7:0] first_byte;
        aclr_n      = 1'b0;
        k_size_6144 = 1'b0;
        in_data     = '0;
        in_valid    = 1'b0;
        in_sof      = 1'b0;
        blk_ack     = 1'b0;
        model_reset();
        @(negedge clk);
        apply_reset();

        $display("[TB] K=6144 ramp block");
        for (int i = 0; i < KMAX/DW; i++) apply_stimulus(1'b1, 8'(i), 1'b0, 1'b1, 1'b0);
        check_state();
        chk("t1_valid",      32'(blk_valid),            32'd1);
        chk("t1_first_byte", 32'(blk_data[6143:6136]),  32'h00);
        chk("t1_last_byte",  32'(blk_data[7:0]),        32'hFF);
        chk("t1_byte_cnt",   32'(byte_cnt),             32'd768);
        chk("t1_in_ready",   32'(in_ready),             32'd0);
        apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        $display("[TB] K=1056 block with k_size toggling");
        for (int i = 0; i < KSMALL/DW; i++)
            apply_stimulus(1'b1, 8'hA5, 1'b0, (i == 0) ? 1'b0 : 1'(i), 1'b0);
        chk("t2_k6144", 32'(blk_k6144), 32'd0);
        chk("t2_valid", 32'(blk_valid), 32'd1);
        for (int i = 0; i < KSMALL/DW; i++) chk("t2_a5_byte", 32'(blk_data[8*i +: 8]), 32'hA5);
        chk("t2_upper_zero", 32'(|blk_data[KMAX-1:KSMALL]), 32'd0);
        apply_stimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);

        $display("[TB] random gaps, delayed ack");
        begin
            logic k;
            k = 1'($urandom);
            for (int i = 0; i < (k ? KMAX/DW : KSMALL/DW); i++) send_byte(8'($urandom), 1'b0, k, 3);
        end
        for (int i = 0; i < 30; i++)
            apply_stimulus(1'($urandom), 8'($urandom), 1'b0, 1'($urandom), 1'b0);
        chk("t3_hold_valid", 32'(blk_valid), 32'd1);
        apply_stimulus(1'b1, 8'h77, 1'b0, 1'b0, 1'b1);
        chk("t3_ack_cnt",     32'(byte_cnt), 32'd0);
        chk("t3_ack_ready",   32'(in_ready), 32'd1);
        apply_stimulus(1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
        chk("t3_deferred_cnt",  32'(byte_cnt),      32'd1);
        chk("t3_deferred_byte", 32'(blk_data[7:0]), 32'h77);
        for (int i = 1; i < KSMALL/DW; i++) send_byte(8'($urandom), 1'b0, 1'($urandom), 2);
        chk("t3_small_full", 32'(blk_valid), 32'd1);
        apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        $display("[TB] restart by in_sof at byte 50");
        for (int i = 0; i < 50; i++) send_byte(8'($urandom), 1'b0, 1'b1, 1);
        apply_stimulus(1'b1, 8'h3C, 1'b1, 1'b1, 1'b0);
        chk("t4_restart_err", 32'(restart_err), 32'd1);
        chk("t4_byte_cnt",    32'(byte_cnt),    32'd1);
        for (int i = 0; i < KMAX/DW - 1; i++) send_byte(8'($urandom), 1'b0, 1'($urandom), 1);
        chk("t4_valid",    32'(blk_valid),           32'd1);
        chk("t4_sof_byte", 32'(blk_data[6143:6136]), 32'h3C);
        chk("t4_no_pulse", 32'(restart_err),         32'd0);
        apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        $display("[TB] reset at byte 400");
        for (int i = 0; i < 400; i++) send_byte(8'($urandom), 1'b0, 1'b1, 0);
        chk("t5_pre_cnt", 32'(byte_cnt), 32'd400);
        apply_reset();
        first_byte = 8'($urandom);
        apply_stimulus(1'b1, first_byte, 1'b0, 1'b1, 1'b0);
        for (int i = 1; i < KMAX/DW; i++) apply_stimulus(1'b1, 8'($urandom), 1'b0, 1'b1, 1'b0);
        check_state();
        chk("t5_valid",      32'(blk_valid),           32'd1);
        chk("t5_first_byte", 32'(blk_data[6143:6136]), 32'(first_byte));
        apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        check_state();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
